// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - Y86-64 execute-stage constants, ALU codes and condition evaluation
package execute_stage_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [2:0] CC_RESET = 3'b100;

  // cc layout is {ZF, SF, OF}
  function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf, sf, of;
    zf = cc[2];
    sf = cc[1];
    of = cc[0];
    case (ifun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = (sf ^ of) | zf;
      C_L:     cond_eval = sf ^ of;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~(sf ^ of);
      C_G:     cond_eval = ~(sf ^ of) & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_cc_unit.sv
// rtl/execute_stage_cc_unit.sv - condition-code register and branch/cmov condition evaluation
module cc_unit
  import execute_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
  input  logic [2:0] flags,
  input  logic [3:0] ifun,
  output logic [2:0] cc,
  output logic       cond
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cc <= CC_RESET;
    end else if (update) begin
      cc <= flags;
    end
  end

  // Condition is judged against the flags before this cycle's update
  assign cond = cond_eval(cc, ifun);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage with ALU, cc and one-deep output register; EXEC_STAT_EN adds stat_block
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  input  logic [3:0]  dstE,
  input  logic        bubble,
`ifdef EXEC_STAT_EN
  input  logic        stat_block,
`endif
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  out_icode,
  output logic [63:0] out_valE,
  output logic [63:0] out_valA,
  output logic [3:0]  out_dstE,
  output logic        out_cnd,
  output logic [2:0]  cc
);

  logic [63:0] alu_a, alu_b, val_e;
  alu_fun_e    alu_fun;
  logic        alu_of;
  logic        cond, cnd, cc_update, cc_allow;
  logic [3:0]  dst_sel;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = ALU_ADD;
    case (icode)
      I_OPQ: begin
        if (ifun[3:2] == 2'b00) begin
          alu_a   = valA;
          alu_b   = valB;
          alu_fun = alu_fun_e'(ifun[1:0]);
        end
      end
      I_IRMOVQ: alu_a = valC;
      I_RRMOVQ: alu_a = valA;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = valC;
        alu_b = valB;
      end
      I_PUSHQ, I_CALL: begin
        alu_a   = 64'd8;
        alu_b   = valB;
        alu_fun = ALU_SUB;
      end
      I_POPQ, I_RET: begin
        alu_a = 64'd8;
        alu_b = valB;
      end
      default: ;
    endcase
  end

  always_comb begin
    val_e  = '0;
    alu_of = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        val_e  = alu_b + alu_a;
        alu_of = (alu_a[63] == alu_b[63]) && (val_e[63] != alu_a[63]);
      end
      ALU_SUB: begin
        val_e  = alu_b - alu_a;
        alu_of = (alu_a[63] != alu_b[63]) && (val_e[63] != alu_b[63]);
      end
      ALU_AND: val_e = alu_b & alu_a;
      ALU_XOR: val_e = alu_b ^ alu_a;
      default: ;
    endcase
  end

`ifdef EXEC_STAT_EN
  assign cc_allow = ~stat_block;
`else
  assign cc_allow = 1'b1;
`endif

  assign in_ready  = ~out_valid | out_ready;
  assign cc_update = in_valid & in_ready & ~bubble & (icode == I_OPQ) & cc_allow;

  cc_unit u_cc (
    .clk    (clk),
    .rst    (rst),
    .update (cc_update),
    .flags  ({(val_e == 64'd0), val_e[63], alu_of}),
    .ifun   (ifun),
    .cc     (cc),
    .cond   (cond)
  );

  assign cnd     = ((icode == I_JXX) || (icode == I_RRMOVQ)) ? cond : 1'b0;
  // A cmov that fails its condition must not write back
  assign dst_sel = ((icode == I_RRMOVQ) && !cnd) ? RNONE : dstE;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_icode <= I_NOP;
      out_valE  <= '0;
      out_valA  <= '0;
      out_dstE  <= RNONE;
      out_cnd   <= 1'b0;
    end else if (in_ready) begin
      if (bubble) begin
        out_valid <= 1'b0;
        out_icode <= I_NOP;
        out_valE  <= '0;
        out_valA  <= '0;
        out_dstE  <= RNONE;
        out_cnd   <= 1'b0;
      end else if (in_valid) begin
        out_valid <= 1'b1;
        out_icode <= icode;
        out_valE  <= val_e;
        out_valA  <= valA;
        out_dstE  <= dst_sel;
        out_cnd   <= cnd;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - scoreboard bench for execute_stage against a behavioural Y86-64 model
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, bubble, out_ready;
  logic [3:0]  icode, ifun, dstE;
  logic [63:0] valA, valB, valC;
  logic        out_valid, out_cnd;
  logic [3:0]  out_icode, out_dstE;
  logic [63:0] out_valE, out_valA;
  logic [2:0]  cc;

  execute_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .dstE(dstE), .bubble(bubble), .out_ready(out_ready),
    .out_valid(out_valid), .out_icode(out_icode), .out_valE(out_valE),
    .out_valA(out_valA), .out_dstE(out_dstE), .out_cnd(out_cnd), .cc(cc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        chk;
    logic [3:0]  icode;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic        cnd;
    logic [2:0]  cc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Reference model: plain Y86-64 semantics
  function automatic logic [63:0] model_vale(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
    case (ic)
      4'h6: case (fn)
              4'h0: return b + a;
              4'h1: return b - a;
              4'h2: return b & a;
              4'h3: return b ^ a;
              default: return 64'd0;
            endcase
      4'h3: return c;
      4'h2: return a;
      4'h4, 4'h5: return b + c;
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic model_of(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] wide;
    if (fn == 4'h0) wide = $signed({b[63], b}) + $signed({a[63], a});
    else if (fn == 4'h1) wide = $signed({b[63], b}) - $signed({a[63], a});
    else return 1'b0;
    return wide[64] != wide[63];
  endfunction

  function automatic logic model_cond(input logic [2:0] c, input logic [3:0] fn);
    bit zf = c[2], sf = c[1], of = c[0];
    bit lt = (sf != of);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic r, input logic iv, input logic bb, input logic ordy,
                      input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ds,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    logic ready, cn;
    logic [63:0] e;
    rst = r; in_valid = iv; bubble = bb; out_ready = ordy;
    icode = ic; ifun = fn; dstE = ds; valA = a; valB = b; valC = c;
    ready = !m.vld || ordy;
    @(posedge clk);
    if (r) begin
      m = '{vld: 1'b0, chk: 1'b1, icode: 4'h1, vale: 64'd0, vala: 64'd0, dste: 4'hF, cnd: 1'b0, cc: 3'b100};
    end else if (ready) begin
      if (bb) begin
        m = '{vld: 1'b0, chk: 1'b1, icode: 4'h1, vale: 64'd0, vala: 64'd0, dste: 4'hF, cnd: 1'b0, cc: m.cc};
      end else if (iv) begin
        cn = (ic == 4'h7 || ic == 4'h2) ? model_cond(m.cc, fn) : 1'b0;
        e  = model_vale(ic, fn, a, b, c);
        m.vld = 1'b1; m.chk = 1'b1; m.icode = ic; m.vale = e; m.vala = a; m.cnd = cn;
        m.dste = (ic == 4'h2 && !cn) ? 4'hF : ds;
        if (ic == 4'h6) m.cc = {e == 64'd0, e[63], model_of(fn, a, b)};
      end else begin
        m.vld = 1'b0;
        m.chk = 1'b0;
      end
    end
    q.push_back(m);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("out_valid", 64'(out_valid), 64'(e.vld));
      check("cc", 64'(cc), 64'(e.cc));
      check("in_ready", 64'(in_ready), 64'(!e.vld || out_ready));
      if (e.chk) begin
        check("out_icode", 64'(out_icode), 64'(e.icode));
        check("out_valE", out_valE, e.vale);
        check("out_valA", out_valA, e.vala);
        check("out_dstE", 64'(out_dstE), 64'(e.dste));
        check("out_cnd", 64'(out_cnd), 64'(e.cnd));
      end
    end
  end

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'($urandom_range(0, 16));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [3:0] ic, fn;
    m = '{vld: 1'b0, chk: 1'b0, icode: 4'h1, vale: 64'd0, vala: 64'd0, dste: 4'hF, cnd: 1'b0, cc: 3'b100};
    step(1, 0, 0, 1, 4'h1, 0, 4'hF, 0, 0, 0);
    step(1, 0, 0, 1, 4'h1, 0, 4'hF, 0, 0, 0);
    step(0, 1, 0, 1, 4'h6, 4'h0, 4'h3, 64'd12345, 64'd999999999, 0);
    step(0, 1, 0, 1, 4'h6, 4'h1, 4'h4, 64'd5, 64'd5, 0);
    step(0, 1, 0, 1, 4'h7, 4'h3, 4'hF, 0, 0, 64'h40);
    step(0, 1, 0, 1, 4'h6, 4'h0, 4'h2, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
    step(0, 1, 0, 1, 4'h2, 4'h2, 4'h5, 64'h1234, 0, 0);
    step(0, 1, 0, 1, 4'hA, 4'h0, 4'h4, 64'h77, 64'h100, 0);
    repeat (3) step(0, 1, 0, 0, 4'h6, 4'h1, 4'h1, 64'd1, 64'd0, 0);
    step(0, 0, 0, 1, 4'h1, 0, 4'hF, 0, 0, 0);
    step(0, 1, 1, 1, 4'h6, 4'h1, 4'h2, 64'd3, 64'd3, 0);
    step(0, 1, 0, 1, 4'h6, 4'h3, 4'h2, 64'hF0, 64'h0F, 0);
    step(0, 1, 0, 0, 4'h6, 4'h1, 4'h2, 64'd9, 64'd9, 0);
    step(1, 1, 0, 0, 4'h6, 4'h1, 4'h2, 64'd9, 64'd9, 0);
    step(0, 1, 0, 1, 4'h5, 4'h0, 4'h6, 64'd1, 64'h1000, 64'h20);
    for (int i = 0; i < 400; i++) begin
      ic = ($urandom_range(0, 9) < 4) ? 4'h6 : 4'($urandom_range(0, 15));
      fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 8));
      step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7, ic, fn, 4'($urandom_range(0, 15)), rand64(), rand64(), rand64());
    end
    step(0, 0, 0, 1, 4'h1, 0, 4'hF, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  decode stage presents an instruction.
REQ-005 in_ready  output  1  stage accepts this cycle.
REQ-006 icode, ifun  input  4 each  Y86-64 instruction code and function.
REQ-007 valA, valB, valC  input  64 each  register operands A and B, and the immediate.
REQ-008 dstE  input  4  destination register (0xF = RNONE).
REQ-009 bubble  input  1  hazard control: inject a NOP into the output register.
REQ-010 out_ready  input  1  memory stage accepts.
REQ-011 out_valid  output  1  output register holds an instruction.
REQ-012 out_icode  output  4; out_valE  output  64; out_valA  output  64; out_dstE  output  4; out_cnd  output  1.
REQ-013 cc  output  3  {ZF,SF,OF} condition-code register.

Function
REQ-014 The block SHALL compute valE combinationally and register it with all out_* fields in one cycle: latency 1.
REQ-015 valE:
- OPQ(6): ifun 0 = valB+valA; 1 = valB-valA; 2 = valB&valA; 3 = valB^valA.
- IRMOVQ(3): 0+valC.
- RRMOVQ/CMOVxx(2): valA+0.
- RMMOVQ(4)/MRMOVQ(5): valB+valC.
- PUSHQ(A)/CALL(8): valB-8.
- POPQ(B)/RET(9): valB+8.
- Other icodes: 0.
REQ-016 Arithmetic SHALL be 64-bit two's complement modulo 2^64; carry-out discarded.
REQ-017 When an OPQ is accepted, cc SHALL update on the same edge:
- ZF = (valE==0).
- SF = valE[63].
- OF: for add, operands share a sign and the result differs; for sub, valB and valA differ in sign and the result sign differs from valB; 0 for and/xor.
REQ-018 cc SHALL NOT change on any non-OPQ instruction, bubble or stalled cycle.
REQ-019 cnd SHALL be evaluated from the current cc for JXX(7) and CMOVxx:
- ifun 0 = 1.
- 1 le = (SF^OF)|ZF.
- 2 l = SF^OF.
- 3 e = ZF.
- 4 ne = !ZF.
- 5 ge = !(SF^OF).
- 6 g = !(SF^OF)&!ZF.
- ifun >6 = 0.
- cnd = 0 for all other icodes.
REQ-020 A CMOVxx with cnd=0 SHALL register out_dstE=0xF.
REQ-021 Handshake: in_ready = !out_valid | out_ready.
- A transfer occurs when in_valid & in_ready.
- Otherwise the output register holds its contents.
REQ-022 bubble SHALL take priority over a transfer when in_ready=1:
- Loads out_valid=0, out_icode=1, out_dstE=0xF, all other fields 0.
- No cc update.
- bubble while in_ready=0 SHALL be ignored.
REQ-023 in_valid=0 with in_ready=1 SHALL clear out_valid.

Reset
REQ-024 rst SHALL set out_valid=0, out_icode=1 (NOP), out_valE=0, out_valA=0, out_dstE=0xF, out_cnd=0 and cc=3'b100 (ZF=1).
REQ-025 rst SHALL override a simultaneous transfer or bubble; an in-flight instruction is discarded.

Configuration
REQ-026 Macro EXEC_STAT_EN SHALL add input stat_block (1 bit, asserted when a later stage holds an exception).
REQ-027 With EXEC_STAT_EN defined, cc SHALL NOT update while stat_block=1; the instruction still transfers.
REQ-028 Without EXEC_STAT_EN, the port is absent and cc updates per REQ-017.

Structure
REQ-029 A shared package/header SHALL hold the icode constants (HALT..POPQ), the ALU function codes, the condition codes (0-6), RNONE=0xF and the cc reset value.
REQ-030 cc storage and cnd evaluation SHALL be a sub-module cc_unit; the ALU datapath stays in execute_stage.

Verification
REQ-031 OPQ add, valA=12345, valB=999999999 -> out_valE=1000012344, cc=000 one cycle later.
REQ-032 OPQ sub, valA=5, valB=5 -> valE=0, cc=100; following JXX ifun 3 -> out_cnd=1.
REQ-033 OPQ add, valA=valB=0x4000000000000000 -> valE=0x8000000000000000, cc=011; following CMOVxx ifun 2 (l) -> cnd=0, out_dstE=0xF.
REQ-034 PUSHQ valB=0x100 with out_ready=0 for 3 cycles -> in_ready=0 and outputs held at valE=0xF8; output released on out_ready=1.
REQ-035 bubble=1 concurrent with OPQ in_valid=1 -> out_valid=0, out_icode=1, cc unchanged.
REQ-036 rst asserted mid-stall with out_valid=1 -> next cycle out_valid=0, cc=100.
